serial_adder_fsm: RTL and testbench
===================================

// Module: serial_adder_fsm
// PURPOSE
//  Bit-serial N-bit adder built around a single structural full-adder cell.
//  Upstream: loads operands a, b and carry-in through a valid/ready handshake.
//  Adds LSB-first, one bit per clock, and keeps the carry in a flop between bits.
//  Downstream: presents sum and carry-out through a valid/ready handshake.
//  Trades WIDTH cycles of latency for one full-adder's area.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=2)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  in_valid   in   1      upstream presents a, b, cin
//  in_ready   out  1      block can accept operands (IDLE only)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in for bit 0
//  out_valid  out  1      sum/cout valid (DONE only)
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  a+b+cin, low WIDTH bits
//  cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; all of the following clear to 0:
//   in_ready=1 once released, out_valid=0, sum=0, cout=0, shift regs, carry flop, bit counter.
//  States: IDLE -> ADD -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1, out_valid=0.
//   - On in_valid & in_ready: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, go to ADD.
//  ADD, every cycle (in_ready=0):
//   - FA inputs: a_sr[0], b_sr[0], carry.
//   - a_sr, b_sr shift right by 1.
//   - FA sum bit shifts into sum_sr MSB (sum_sr shifts right).
//   - carry<=FA cout; cnt<=cnt+1.
//   - When cnt==WIDTH-1: perform that final bit as above, load sum<=final sum_sr,
//     cout<=final FA cout, go to DONE.
//  DONE:
//   - out_valid=1; sum/cout held stable while out_valid & !out_ready.
//   - On out_ready: go to IDLE; out_valid drops next cycle.
//  Latency: operands accepted at edge E -> out_valid=1 after edge E+WIDTH.
//  Throughput: one add per WIDTH+2 cycles minimum (accept, WIDTH bits, drain).
//  sum/cout are registered outputs; they change only on DONE entry or reset.
//  in_valid while in ADD/DONE: ignored (in_ready=0); upstream must hold it.
//  out_ready while not in DONE: ignored.
//  Carry wrap: carry out of bit WIDTH-1 goes only to cout and never re-enters.
//  Reset mid-ADD or mid-DONE: immediate abort, in-flight result discarded,
//   outputs cleared as above.
//  Counter width: $clog2(WIDTH); the terminal compare is against WIDTH-1, so no overflow.
//  Illegal/unused state encodings: recover to IDLE on the next clock.
// STRUCTURE
//  Shared include adder_defs.vh: state localparams S_IDLE=2'd0, S_ADD=2'd1,
//   S_DONE=2'd2; default WIDTH.
//  Sub-module: exactly one full_adder_st2 instance (s, cout, a, b, cin) as the bit cell.
//   No behavioural '+' on the datapath.
//  Rest of the block: one FSM always block plus one datapath always block
//   (a_sr, b_sr, sum_sr, carry, cnt).
// TESTING
//  1 Reset: hold rst_n=0 for 3 clk -> out_valid=0, sum=0, cout=0;
//    after release, in_ready=1.
//  2 WIDTH=8: a=0x5A, b=0x33, cin=0 -> sum=0x8D, cout=0;
//    out_valid rises exactly 8 edges after the accept edge.
//  3 Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1;
//    a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout stable;
//    new in_valid during ADD/DONE sees in_ready=0 and is not consumed.
//  5 Reset mid-op: drop rst_n at bit 3 of a=0xAA+b=0x55 -> out_valid=0 and sum=0
//    at once (no clock needed); after release, next add a=1, b=2, cin=0 -> sum=0x03.
//  6 Random: 200 vectors with random in_valid/out_ready gaps;
//    {cout,sum} == a+b+cin for every handshake; no lost or duplicated results.

Source files
------------

// File: rtl/serial_adder_fsm_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm_pkg
// Shared definitions for the bit-serial adder.
//   state_t        : controller states (IDLE -> ADD -> DONE -> IDLE)
//   DEFAULT_WIDTH  : default operand/sum width
// -----------------------------------------------------------------------------
package serial_adder_fsm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_st2.sv
// -----------------------------------------------------------------------------
// full_adder_st2
// One-bit full adder cell built from gate-level logic.
// Ports:
//   a, b, cin : input bits
//   s         : sum bit  (a ^ b ^ cin)
//   cout      : carry out (majority of a, b, cin)
// -----------------------------------------------------------------------------
module full_adder_st2 (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    logic half_s;

    assign half_s = a ^ b;
    assign s      = half_s ^ cin;
    assign cout   = (a & b) | (cin & half_s);

endmodule

// File: rtl/serial_adder_fsm.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm
// Bit-serial WIDTH-bit adder: one full-adder cell processes the operands
// LSB-first, one bit per clock, with the carry kept in a flop between bits.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (a, b, cin); ready only in IDLE
//   a, b, cin             : operands and carry-in for bit 0
//   out_valid / out_ready : result handshake; valid only in DONE
//   sum, cout             : registered result, low WIDTH bits and carry out
// -----------------------------------------------------------------------------
module serial_adder_fsm
    import serial_adder_fsm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic fa_s;
    logic fa_cout;
    logic accept;
    logic last_bit;

    full_adder_st2 u_fa (
        .s    (fa_s),
        .cout (fa_cout),
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry)
    );

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt == LAST_BIT);

    // Controller and registered outputs. in_ready resets high because the
    // block is in IDLE as soon as reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_ADD;
                        in_ready <= 1'b0;
                    end
                end
                S_ADD: begin
                    if (last_bit) begin
                        // Final bit: capture the completed sum straight from
                        // the shift input so the result is ready on DONE entry.
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        sum       <= {fa_s, sum_sr[WIDTH-1:1]};
                        cout      <= fa_cout;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Serial datapath: operands shift out LSB-first, sum bits shift in at
    // the MSB so that after WIDTH steps sum_sr holds the aligned result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (state == S_IDLE) begin
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                cnt   <= '0;
            end
        end else if (state == S_ADD) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_adder_fsm.sv
module tb_serial_adder_fsm;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks;
    int n_errors;

    serial_adder_fsm #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the full (WIDTH+1)-bit arithmetic sum.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // One complete transaction. Inputs change at posedge+1, outputs are
    // read at posedge+1 or negedge. Optionally keeps a second in_valid
    // asserted while busy and confirms it is refused.
    task automatic run_op(input string tag,
                          input logic [WIDTH-1:0] xa,
                          input logic [WIDTH-1:0] xb,
                          input logic xc,
                          input int hold,
                          input bit busy_push);
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] s0;
        logic             c0;
        int               lat;
        bit               ok;
        exp = ref_add(xa, xb, xc);
        a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b0;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        check({tag, "_accept_timeout"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (busy_push) begin
            a = ~xa; b = ~xb; cin = ~xc;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        for (int t = 0; t < 50; t++) begin
            if (out_valid) break;
            if (busy_push) check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
        check({tag, "_sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(exp[WIDTH]));
        s0 = sum; c0 = cout;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_sum"}, 32'(sum), 32'(s0));
            check({tag, "_hold_cout"}, 32'(cout), 32'(c0));
            if (busy_push) check({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    logic [WIDTH:0] exp_q[$];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 2, 3: directed sums
        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 0, 0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 0, 0);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 0, 0);

        // 4: backpressure plus refused in_valid while busy
        run_op("bp", 8'hC3, 8'h7E, 1'b1, 5, 1);
        run_op("after_bp", 8'h10, 8'h20, 1'b0, 0, 0);
        run_op("nz_sum", 8'hF0, 8'h0E, 1'b1, 0, 0);

        // 5: asynchronous reset in the middle of an add
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 8'h01, 8'h02, 1'b0, 0, 0);

        // 6: random traffic with independent gaps on both sides
        begin
            int produced, consumed, gap;
            bit acc_in;
            logic [WIDTH:0] e;
            produced = 0; consumed = 0; gap = 0;
            in_valid = 1'b0; out_ready = 1'b0;
            for (int cyc = 0; cyc < 20000 && consumed < 200; cyc++) begin
                @(negedge clk);
                acc_in = in_valid && in_ready;
                if (acc_in) begin
                    exp_q.push_back(ref_add(a, b, cin));
                    produced++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rand_spurious_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rand_sum", 32'(sum), 32'(e[WIDTH-1:0]));
                        check("rand_cout", 32'(cout), 32'(e[WIDTH]));
                    end
                    consumed++;
                end
                @(posedge clk); #1;
                if (acc_in) begin
                    in_valid = 1'b0;
                    gap = $urandom_range(0, 3);
                end
                if (!in_valid && produced < 200) begin
                    if (gap == 0) begin
                        a = WIDTH'($urandom);
                        b = WIDTH'($urandom);
                        cin = 1'($urandom);
                        in_valid = 1'b1;
                    end else begin
                        gap--;
                    end
                end
                out_ready = ($urandom_range(0, 2) != 0);
            end
            in_valid = 1'b0; out_ready = 1'b0;
            check("rand_produced", 32'(produced), 32'd200);
            check("rand_consumed", 32'(consumed), 32'd200);
            check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
